// File: rtl/sprite_pkg.sv
// Shared sprite geometry, register layout and bitmap contents for the sprite engine.
package sprite_pkg;

    localparam int unsigned SPR_W    = 16;
    localparam int unsigned SPR_H    = 32;
    localparam int unsigned COLOR_W  = 3;
    localparam int unsigned N_IMAGES = 4;
    localparam int unsigned ROAD_W   = 256;

    localparam logic [COLOR_W-1:0] TRANSPARENT = '0;

    localparam int unsigned X_W    = $clog2(ROAD_W);
    localparam int unsigned Y_W    = 10;
    localparam int unsigned IMG_W  = $clog2(N_IMAGES);
    localparam int unsigned LX_W   = $clog2(SPR_W);
    localparam int unsigned LY_W   = $clog2(SPR_H);
    localparam int unsigned ROM_AW = IMG_W + LY_W + LX_W;

    typedef struct packed {
        logic [X_W-1:0]   x;
        logic [Y_W-1:0]   y;
        logic             en;
        logic [IMG_W-1:0] img;
    } sprite_regs_t;

    // Index width that stays >= 1 even for a single entry.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Bitmap pattern: colour = (lx + 2*ly + 3*img) mod 8, colour 0 is a transparent hole.
    function automatic logic [COLOR_W-1:0] rom_pixel(input logic [ROM_AW-1:0] addr);
        logic [IMG_W-1:0] img;
        logic [LY_W-1:0]  ly;
        logic [LX_W-1:0]  lx;
        logic [7:0]       sum;
        {img, ly, lx} = addr;
        sum = 8'(lx) + {2'b00, ly, 1'b0} + 8'(img) + 8'(img) + 8'(img);
        return sum[COLOR_W-1:0];
    endfunction

endpackage

// File: rtl/sprite_rom.sv
// Synchronous single-port bitmap ROM, one read per cycle with one cycle of latency.
module sprite_rom
    import sprite_pkg::*;
(
    input  logic               clk,
    input  logic [ROM_AW-1:0]  addr,
    output logic [COLOR_W-1:0] data
);

    always_ff @(posedge clk) begin
        data <= rom_pixel(addr);
    end

endmodule

// File: rtl/graphic_sprite_engine.sv
// N-sprite renderer: double-buffered sprite registers, per-pixel hit test, bitmap lookup,
// lowest-index-wins priority and per-frame player collision reporting.
module graphic_sprite_engine
    import sprite_pkg::*;
#(
    parameter  int unsigned N_SPRITES = 4,
    parameter  int unsigned ROAD_X0   = 256,
    localparam int unsigned IDX_W     = idx_w(N_SPRITES)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 frame_tick,
    input  logic                 pos_we,
    input  logic [IDX_W-1:0]     pos_idx,
    input  logic [X_W-1:0]       pos_x,
    input  logic [Y_W-1:0]       pos_y,
    input  logic                 pos_en,
    input  logic [IMG_W-1:0]     pos_img,
    input  logic [9:0]           pixel_x,
    input  logic [9:0]           pixel_y,
    input  logic                 video_on,
    output logic [COLOR_W-1:0]   rgb,
    output logic                 on,
    output logic [IDX_W-1:0]     hit_idx,
    output logic [N_SPRITES-1:0] collide_vec,
    output logic                 collide_valid
);

    sprite_regs_t shadow_q [N_SPRITES];
    sprite_regs_t active_q [N_SPRITES];
    sprite_regs_t wr_val;

    assign wr_val = {pos_x, pos_y, pos_en, pos_img};

    // A write landing on the frame_tick cycle goes straight through to the active copy.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_SPRITES; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_SPRITES; i++) begin
                if (pos_we && pos_idx == IDX_W'(i)) begin
                    shadow_q[i] <= wr_val;
                end
                if (frame_tick) begin
                    active_q[i] <= (pos_we && pos_idx == IDX_W'(i)) ? wr_val : shadow_q[i];
                end
            end
        end
    end

    logic [10:0]          rx;
    logic [10:0]          py;
    logic                 in_road;
    logic [N_SPRITES-1:0] hit_s0;
    logic [N_SPRITES-1:0] hit_s1;
    logic [N_SPRITES-1:0] opaque;
    logic [COLOR_W-1:0]   pix [N_SPRITES];
    logic [LX_W-1:0]      lx  [N_SPRITES];
    logic [LY_W-1:0]      ly  [N_SPRITES];

    // Left of the road wraps to a large 11-bit value and fails the range check.
    assign rx      = {1'b0, pixel_x} - 11'(ROAD_X0);
    assign py      = {1'b0, pixel_y};
    assign in_road = rx < 11'(ROAD_W);

    for (genvar g = 0; g < N_SPRITES; g++) begin : g_spr
        logic [10:0] x_lo;
        logic [10:0] y_lo;

        assign x_lo = 11'(active_q[g].x);
        assign y_lo = 11'(active_q[g].y);

        // Upper bounds are 11-bit sums so edge sprites clip instead of wrapping.
        assign hit_s0[g] = video_on & in_road & active_q[g].en
                         & (rx >= x_lo) & (rx < x_lo + 11'(SPR_W))
                         & (py >= y_lo) & (py < y_lo + 11'(SPR_H));

        assign lx[g] = rx[LX_W-1:0] - active_q[g].x[LX_W-1:0];
        assign ly[g] = pixel_y[LY_W-1:0] - active_q[g].y[LY_W-1:0];

        sprite_rom u_rom (
            .clk  (clk),
            .addr ({active_q[g].img, ly[g], lx[g]}),
            .data (pix[g])
        );

        assign opaque[g] = hit_s1[g] & (pix[g] != TRANSPARENT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hit_s1 <= '0;
        end else begin
            hit_s1 <= hit_s0;
        end
    end

    logic [COLOR_W-1:0] rgb_d;
    logic               on_d;
    logic [IDX_W-1:0]   idx_d;

    always_comb begin
        rgb_d = '0;
        on_d  = 1'b0;
        idx_d = '0;
        for (int i = N_SPRITES - 1; i >= 0; i--) begin
            if (opaque[i]) begin
                rgb_d = pix[i];
                on_d  = 1'b1;
                idx_d = IDX_W'(i);
            end
        end
    end

    logic [N_SPRITES-1:0] pair;
    logic [N_SPRITES-1:0] acc_q;

    always_comb begin
        pair    = opaque & {N_SPRITES{opaque[0]}};
        pair[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rgb           <= '0;
            on            <= 1'b0;
            hit_idx       <= '0;
            acc_q         <= '0;
            collide_vec   <= '0;
            collide_valid <= 1'b0;
        end else begin
            rgb           <= rgb_d;
            on            <= on_d;
            hit_idx       <= idx_d;
            collide_valid <= frame_tick;
            if (frame_tick) begin
                collide_vec <= acc_q | pair;
                acc_q       <= '0;
            end else begin
                acc_q <= acc_q | pair;
            end
        end
    end

endmodule
